// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with tick-based debounce and ghost rejection.
// Press confirmed after DEBOUNCE_TICKS+1 matching ticks; no backpressure, key_strobe is a one-cycle pulse.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic       key_strobe
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DCNT_W = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        ri;
  logic [1:0]        cand_row;
  logic [3:0]        cand_col;
  logic [DIV_W-1:0]  div;
  logic [DCNT_W-1:0] dcnt;
  logic [3:0]        sync1;
  logic [3:0]        sync2;
  logic [3:0]        cs;
  logic              tick;
  logic              cs_one_hot;
  logic              dcnt_done;

  // Inversion sits ahead of the flops so their reset value of 0 reads as "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 4'd0;
      sync2 <= 4'd0;
    end else begin
      sync1 <= ~col_in;
      sync2 <= sync1;
    end
  end

  assign cs         = sync2;
  assign tick       = (div == DIV_W'(SCAN_DIV - 1));
  assign cs_one_hot = (cs != 4'd0) && ((cs & (cs - 4'd1)) == 4'd0);
  assign dcnt_done  = (dcnt == DCNT_W'(DEBOUNCE_TICKS - 1));
  assign row_out    = ~(4'b0001 << ri);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SCAN;
      ri         <= 2'd0;
      cand_row   <= 2'd0;
      cand_col   <= 4'd0;
      dcnt       <= '0;
      row        <= 4'd0;
      col        <= 4'd0;
      key_valid  <= 1'b0;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            // Multi-bit columns mean ghosting or a chord; skip the row rather than guess.
            if (cs_one_hot) begin
              cand_row <= ri;
              cand_col <= cs;
              dcnt     <= '0;
              state    <= DEBOUNCE;
            end else begin
              ri <= ri + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (cs == cand_col) begin
              if (dcnt_done) begin
                state      <= HELD;
                row        <= 4'b0001 << cand_row;
                col        <= cand_col;
                key_valid  <= 1'b1;
                key_strobe <= 1'b1;
              end else begin
                dcnt <= dcnt + DCNT_W'(1);
              end
            end else begin
              state <= SCAN;
              ri    <= ri + 2'd1;
            end
          end
          HELD: begin
            if (cs != cand_col) begin
              state     <= RELEASE;
              dcnt      <= '0;
              row       <= 4'd0;
              col       <= 4'd0;
              key_valid <= 1'b0;
            end
          end
          default: begin
            if (cs != 4'd0) begin
              dcnt <= '0;
            end else if (dcnt_done) begin
              state <= SCAN;
              ri    <= ri + 2'd1;
            end else begin
              dcnt <= dcnt + DCNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed table-driven bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_TICKS=3.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic       key_strobe;

  logic press = 1'b0;
  logic ghost = 1'b0;

  int checks = 0;
  int errors = 0;
  int strobes;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_in     (col_in),
    .row_out    (row_out),
    .row        (row),
    .col        (col),
    .key_valid  (key_valid),
    .key_strobe (key_strobe)
  );

  always #5 clk = ~clk;

  // Key at row2/col1; ghost mode pulls columns 1 and 2 low on row 2.
  always_comb begin
    col_in = 4'hF;
    if (row_out == 4'b1011) begin
      if (ghost)      col_in = 4'b1001;
      else if (press) col_in = 4'b1101;
    end
  end

  typedef struct {
    logic       rst;
    logic       press;
    logic       ghost;
    int         ncyc;
    logic [3:0] e_ro;
    logic       e_v;
    int         e_stb;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic p, input logic g, input int n,
                     input logic [3:0] ro, input logic v, input int s);
    vec_t t;
    t.rst = r; t.press = p; t.ghost = g; t.ncyc = n;
    t.e_ro = ro; t.e_v = v; t.e_stb = s;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    strobes = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_strobe) strobes++;
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] ro, input logic v, input int s);
    chk({tag, " row_out"}, 32'(row_out), 32'(ro));
    chk({tag, " key_valid"}, 32'(key_valid), 32'(v));
    chk({tag, " row"}, 32'(row), v ? 32'h4 : 32'h0);
    chk({tag, " col"}, 32'(col), v ? 32'h2 : 32'h0);
    chk({tag, " strobes"}, 32'(strobes), 32'(s));
  endtask

  initial begin
    // Idle scan: row_out rotates every 4 clk.
    add(1, 0, 0, 0, 4'b1110, 0, 0);
    add(0, 0, 0, 4, 4'b1101, 0, 0); add(0, 0, 0, 4, 4'b1011, 0, 0);
    add(0, 0, 0, 4, 4'b0111, 0, 0); add(0, 0, 0, 4, 4'b1110, 0, 0);
    add(0, 0, 0, 4, 4'b1101, 0, 0); add(0, 0, 0, 4, 4'b1011, 0, 0);
    add(0, 0, 0, 4, 4'b0111, 0, 0); add(0, 0, 0, 4, 4'b1110, 0, 0);
    add(0, 0, 0, 4, 4'b1101, 0, 0); add(0, 0, 0, 4, 4'b1011, 0, 0);
    // Clean press: capture on tick 3, held after tick 6, then clean release.
    add(1, 1, 0, 0, 4'b1110, 0, 0);
    add(0, 1, 0, 4, 4'b1101, 0, 0); add(0, 1, 0, 4, 4'b1011, 0, 0);
    add(0, 1, 0, 4, 4'b1011, 0, 0); add(0, 1, 0, 4, 4'b1011, 0, 0);
    add(0, 1, 0, 4, 4'b1011, 0, 0); add(0, 1, 0, 4, 4'b1011, 1, 1);
    add(0, 1, 0, 4, 4'b1011, 1, 0);
    add(0, 0, 0, 4, 4'b1011, 0, 0); add(0, 0, 0, 4, 4'b1011, 0, 0);
    add(0, 0, 0, 4, 4'b1011, 0, 0); add(0, 0, 0, 4, 4'b0111, 0, 0);
    add(0, 0, 0, 4, 4'b1110, 0, 0);
    // Bounce on the 2nd tick after capture, then a clean hold.
    add(1, 1, 0, 0, 4'b1110, 0, 0);
    add(0, 1, 0, 4, 4'b1101, 0, 0); add(0, 1, 0, 4, 4'b1011, 0, 0);
    add(0, 1, 0, 4, 4'b1011, 0, 0); add(0, 1, 0, 4, 4'b1011, 0, 0);
    add(0, 0, 0, 4, 4'b0111, 0, 0);
    add(0, 1, 0, 4, 4'b1110, 0, 0); add(0, 1, 0, 4, 4'b1101, 0, 0);
    add(0, 1, 0, 4, 4'b1011, 0, 0); add(0, 1, 0, 4, 4'b1011, 0, 0);
    add(0, 1, 0, 4, 4'b1011, 0, 0); add(0, 1, 0, 4, 4'b1011, 0, 0);
    add(0, 1, 0, 4, 4'b1011, 1, 1); add(0, 1, 0, 4, 4'b1011, 1, 0);
    // Ghosting: two columns on one row never enter debounce.
    add(1, 0, 1, 0, 4'b1110, 0, 0);
    add(0, 0, 1, 4, 4'b1101, 0, 0); add(0, 0, 1, 4, 4'b1011, 0, 0);
    add(0, 0, 1, 4, 4'b0111, 0, 0); add(0, 0, 1, 4, 4'b1110, 0, 0);
    add(0, 0, 1, 4, 4'b1101, 0, 0); add(0, 0, 1, 4, 4'b1011, 0, 0);
    add(0, 0, 1, 4, 4'b0111, 0, 0);
    // Release with a one-tick re-press glitch restarting the release count.
    add(1, 1, 0, 0, 4'b1110, 0, 0);
    add(0, 1, 0, 4, 4'b1101, 0, 0); add(0, 1, 0, 4, 4'b1011, 0, 0);
    add(0, 1, 0, 4, 4'b1011, 0, 0); add(0, 1, 0, 4, 4'b1011, 0, 0);
    add(0, 1, 0, 4, 4'b1011, 0, 0); add(0, 1, 0, 4, 4'b1011, 1, 1);
    add(0, 1, 0, 4, 4'b1011, 1, 0);
    add(0, 0, 0, 4, 4'b1011, 0, 0); add(0, 0, 0, 4, 4'b1011, 0, 0);
    add(0, 1, 0, 4, 4'b1011, 0, 0);
    add(0, 0, 0, 4, 4'b1011, 0, 0); add(0, 0, 0, 4, 4'b1011, 0, 0);
    add(0, 0, 0, 4, 4'b0111, 0, 0); add(0, 0, 0, 4, 4'b1110, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      press = vq[i].press;
      ghost = vq[i].ghost;
      if (vq[i].rst) do_reset();
      run(vq[i].ncyc);
      check_outs($sformatf("vec%0d", i), vq[i].e_ro, vq[i].e_v, vq[i].e_stb);
    end

    // Asynchronous reset in the middle of HELD, key kept pressed throughout.
    press = 1'b1;
    ghost = 1'b0;
    do_reset();
    run(28);
    check_outs("pre_reset_held", 4'b1011, 1'b1, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    strobes = 0;
    check_outs("async_reset", 4'b1110, 1'b0, 0);
    chk("async_reset key_strobe", 32'(key_strobe), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(20);
    check_outs("rearm_pending", 4'b1011, 1'b0, 0);
    run(4);
    check_outs("rearm_confirm", 4'b1011, 1'b1, 1);
    run(8);
    check_outs("rearm_hold", 4'b1011, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
